div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle iterative integer divider for the execute stage; covers the LoongArch DIV.W, MOD.W, DIV.WU and MOD.WU operations, which the single-cycle ALU cannot perform.
- Sequences a one-bit restoring subtract step over 32 cycles using a small FSM.
- Valid/ready handshake on both sides, so the pipeline stalls on in_ready/out_valid.
- Supports pipeline flush from exception or branch redirect.

Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  kill any in-flight operation
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_op  in  div_op_t  DIV / DIVU / MOD / MODU
- in_a  in  WIDTH  dividend
- in_b  in  WIDTH  divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_result  out  WIDTH  quotient or remainder

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. On reset the state is IDLE, in_ready=1, out_valid=0 and out_result=0.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. Accept when in_valid&&in_ready.
  - On accept, latch the op and signs. For signed ops, convert operands to magnitudes. Clear the remainder register, load the quotient register with |a|, set cnt=WIDTH-1, go to CALC.
  - CALC: each cycle, div_step shifts {rem,quo} left by 1 and trial-subtracts |b|. If no borrow, rem=diff and the quotient LSB is 1; otherwise the quotient LSB is 0. Decrement cnt. When cnt==0, apply sign fixup, register the result and go to DONE.
  - DONE: out_valid=1 and out_result is held stable until out_ready. On out_valid&&out_ready, go to IDLE.
- Latency: accept in cycle T. CALC runs in cycles T+1..T+32. out_valid is first high in T+33. A new request can be accepted the cycle after the handshake completes (no overlap).
- Sign rules for signed ops:
  - Quotient is negated iff sign(a)!=sign(b). Truncation is toward zero.
  - Remainder takes the sign of the dividend.
- Division by zero (all ops): quotient=all-ones, remainder=a unmodified. The full latency is still used.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000, and MOD gives 0. This falls out of the magnitude arithmetic; no special case is needed.
- Flush:
  - In any state, the next state is IDLE, out_valid drops the next cycle, and no response is produced.
  - Flush takes priority over a same-cycle accept; that request is dropped.
  - Flush in DONE while out_ready=1: the handshake still completes in that cycle (the consumer owns the flush ordering).
- in_op, in_a and in_b are don't-care while not accepting.
- Reset mid-CALC or mid-DONE: immediate return to IDLE and outputs go to their reset values.
- Arithmetic: unsigned magnitudes. The trial subtract is WIDTH+1 bits wide; bit WIDTH is the borrow.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined: at accept, if in_b==0 or |a|<|b|, skip CALC and enter DONE in T+1.
  - Result for b==0: as defined above.
  - Result for |a|<|b|: quotient 0, remainder a.
- When undefined: every operation takes 33 cycles. Results are identical in both builds.

Decomposition:
- Shared cpu_defs package:
  - div_op_t enum {DIV, DIVU, MOD, MODU}.
  - The existing u32_t.
  - div_state_t for the FSM.
- Sub-module div_step: combinational single iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once in div_unit.

Test Plan:
- DIVU 100/7, out_ready=1 -> out_result=14, out_valid exactly 33 cycles after accept, in_ready=0 during the whole operation; MODU 100/7 -> 2.
- DIV -7/2 -> 0xFFFFFFFD; MOD -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; MOD 7/-2 -> 1.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; MOD same operands -> 0.
- DIVU 5/0 -> 0xFFFFFFFF; MODU 5/0 -> 5; DIV -5/0 -> 0xFFFFFFFF; MOD -5/0 -> 0xFFFFFFFB. With DIV_EARLY_OUT_EN these are ready in T+1.
- Flush asserted 10 cycles after accept -> out_valid never rises, in_ready=1 next cycle; a following DIVU 9/3 returns 3 correctly. Flush together with in_valid in IDLE -> request dropped.
- out_ready held 0 for 5 cycles in DONE -> out_valid and out_result held stable; in_ready stays 0 until the handshake completes.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared execute-stage definitions: 32-bit word type, divider op codes and
// divider FSM state encodings.
package cpu_defs;

  typedef logic [31:0] u32_t;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    MOD  = 2'd2,
    MODU = 2'd3
  } div_op_t;

  typedef logic [1:0] div_state_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic op_is_signed(input div_op_t op);
    return (op == DIV) || (op == MOD);
  endfunction

  function automatic logic op_is_mod(input div_op_t op);
    return (op == MOD) || (op == MODU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one and
// trial-subtract the divisor, keeping the difference when it does not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_borrow;

  // Bit WIDTH of the widened difference is the borrow out of the trial subtract.
  assign w_shift  = {i_rem, i_quo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, i_divisor};
  assign w_borrow = w_diff[WIDTH];

  assign o_rem = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_borrow};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle iterative divider for DIV.W/MOD.W/DIV.WU/MOD.WU with valid/ready
// handshakes and flush. Define DIV_EARLY_OUT_EN to finish b==0 and |a|<|b| at once.
module div_unit
  import cpu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  div_op_t          in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_is_mod;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_accept;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_fin_result;

  function automatic logic [WIDTH-1:0] sign_fixup(
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] rem,
    input logic             is_mod,
    input logic             neg_q,
    input logic             neg_r
  );
    if (is_mod) return neg_r ? -rem : rem;
    return neg_q ? -quo : quo;
  endfunction

  assign w_signed = op_is_signed(in_op);
  assign w_a_neg  = w_signed & in_a[WIDTH-1];
  assign w_b_neg  = w_signed & in_b[WIDTH-1];
  assign w_b_zero = (in_b == '0);
  assign w_a_abs  = w_a_neg ? -in_a : in_a;
  assign w_b_abs  = w_b_neg ? -in_b : in_b;
  assign w_accept = in_valid && (r_state == S_IDLE) && !flush;

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_result;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_div),
    .o_rem     (w_rem_nxt),
    .o_quo     (w_quo_nxt)
  );

  assign w_fin_result = sign_fixup(w_quo_nxt, w_rem_nxt, r_is_mod, r_neg_q, r_neg_r);

`ifdef DIV_EARLY_OUT_EN
  logic             w_early;
  logic [WIDTH-1:0] w_early_result;

  // Both shortcut cases leave the dividend as the remainder, untouched by sign fixup.
  assign w_early        = w_b_zero || (w_a_abs < w_b_abs);
  assign w_early_result = op_is_mod(in_op) ? in_a : (w_b_zero ? '1 : '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
`ifdef DIV_EARLY_OUT_EN
            if (w_early) begin
              r_state  <= S_DONE;
              r_result <= w_early_result;
            end else begin
              r_state <= S_CALC;
              r_cnt   <= CNT_W'(WIDTH - 1);
            end
`else
            r_state <= S_CALC;
            r_cnt   <= CNT_W'(WIDTH - 1);
`endif
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_state  <= S_DONE;
            r_result <= w_fin_result;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are fully reloaded on every accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rem    <= '0;
      r_quo    <= w_a_abs;
      r_div    <= w_b_abs;
      r_is_mod <= op_is_mod(in_op);
      r_neg_q  <= w_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]) & ~w_b_zero;
      r_neg_r  <= w_a_neg;
    end else if (r_state == S_CALC) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: arithmetic results, latency,
// division by zero, signed overflow, flush, backpressure and async reset.
module tb_div_unit;
  import cpu_defs::*;

  localparam int W        = 32;
  localparam int LAT_FULL = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_EARLY = 0;
`else
  localparam int LAT_EARLY = 32;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  div_op_t      in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the output handshake.
  task automatic run_op(input string tag, input div_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int   n;
    int   guard;
    logic busy_bad;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    n        = 0;
    busy_bad = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) busy_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (in_ready) busy_bad = 1'b1;
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_res"}, out_result, exp);
    chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic watch_quiet(input string tag, input int ncyc);
    logic seen;
    seen = 1'b0;
    repeat (ncyc) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int   n;
    logic bad;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_op     = DIVU;
    in_a      = '0;
    in_b      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, LAT_FULL);
    run_op("modu_100_7", MODU, 32'd100, 32'd7, 32'd2, LAT_FULL);
    run_op("div_m7_2",   DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_FULL);
    run_op("mod_m7_2",   MOD,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_FULL);
    run_op("div_7_m2",   DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_FULL);
    run_op("mod_7_m2",   MOD,  32'd7, 32'hFFFF_FFFE, 32'd1, LAT_FULL);
    run_op("div_ovf",    DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_FULL);
    run_op("mod_ovf",    MOD,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_FULL);
    run_op("divu_big",   DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, LAT_FULL);
    run_op("modu_big",   MODU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, LAT_FULL);
    run_op("divu_5_0",   DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_EARLY);
    run_op("modu_5_0",   MODU, 32'd5, 32'd0, 32'd5, LAT_EARLY);
    run_op("div_m5_0",   DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, LAT_EARLY);
    run_op("mod_m5_0",   MOD,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_EARLY);
    run_op("divu_3_100", DIVU, 32'd3, 32'd100, 32'd0, LAT_EARLY);
    run_op("mod_m3_100", MOD,  32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFFD, LAT_EARLY);

    // Flush ten cycles into a calculation.
    in_valid = 1'b1; in_op = DIVU; in_a = 32'd1000; in_b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    watch_quiet("flush_quiet", 40);
    run_op("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, LAT_FULL);

    // Flush coinciding with a request in IDLE drops the request.
    in_valid = 1'b1; flush = 1'b1; in_op = DIVU; in_a = 32'd9; in_b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("drop_ready", 32'(in_ready), 32'd1);
    watch_quiet("drop_quiet", 40);

    // Backpressure in DONE.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = DIVU; in_a = 32'd100; in_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_lat", 32'(n), 32'(LAT_FULL));
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (!out_valid || out_result !== 32'd14 || in_ready) bad = 1'b1;
    end
    chk("bp_hold", 32'(bad), 32'd0);
    chk("bp_result", out_result, 32'd14);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of a calculation.
    in_valid = 1'b1; in_op = MODU; in_a = 32'd50; in_b = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_result", out_result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("modu_50_6", MODU, 32'd50, 32'd6, 32'd2, LAT_FULL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
